// File: rtl/kws_mac_bank_cfu_pkg.sv
// Shared types and constants for the KWS MAC-bank custom function unit.
package kws_cfu_pkg;

  typedef enum logic [2:0] {
    SET_OFFSET = 3'd0,
    MAC        = 3'd1,
    READ_ACC   = 3'd2,
    SET_ACC    = 3'd3,
    REQUANT    = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RQ_MUL = 2'd1,
    RQ_RND = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
  } fid_t;

  localparam logic signed [31:0] INT8_MIN  = -32'sd128;
  localparam logic signed [31:0] INT8_MAX  = 32'sd127;
  localparam logic [31:0]        INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/kws_requant_unit.sv
// Two-stage fused requantize: 64-bit product, then rounding doubling high
// multiply, rounding shift, output offset and int8 clamp.
module kws_requant_unit
  import kws_cfu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] x_i,
  input  logic [31:0] m_i,
  input  logic [4:0]  shift_i,
  input  logic [15:0] out_off_i,
  output logic        valid_o,
  output logic [31:0] y_o
);

  logic signed [63:0] prod_c, p_q, nudged_c, biased_c;
  logic               sat_q, p_vld_q, valid_q;
  logic [4:0]         shift_q;
  logic [15:0]        oo_q;
  logic [31:0]        h_c, mask_c, rem_c, thr_c, shr_c, y_c, y_q;
  logic signed [33:0] r_c;
  logic               unused_bits;

  assign prod_c      = 64'($signed(x_i)) * 64'($signed(m_i));
  assign unused_bits = biased_c[63];

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      sat_q   <= 1'b0;
      shift_q <= '0;
      oo_q    <= '0;
      p_vld_q <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
    end else begin
      p_vld_q <= start_i;
      valid_q <= p_vld_q;
      if (start_i) begin
        p_q     <= prod_c;
        sat_q   <= (x_i == INT32_MIN) && (m_i == INT32_MIN);
        shift_q <= shift_i;
        oo_q    <= out_off_i;
      end
      if (p_vld_q) y_q <= y_c;
    end
  end

  // Truncating divide by 2^31 is done as a biased arithmetic shift.
  always_comb begin
    nudged_c = p_q + (p_q[63] ? -64'sd1073741823 : 64'sd1073741824);
    biased_c = nudged_c + (nudged_c[63] ? 64'sd2147483647 : 64'sd0);
    h_c      = sat_q ? 32'h7FFF_FFFF : biased_c[62:31];
    mask_c   = (32'd1 << shift_q) - 32'd1;
    rem_c    = h_c & mask_c;
    thr_c    = (mask_c >> 1) + 32'(h_c[31]);
    shr_c    = 32'($signed(h_c) >>> shift_q);
    r_c      = 34'($signed(shr_c)) + 34'($signed({1'b0, rem_c > thr_c}))
             + 34'($signed(oo_q));
    if (r_c < 34'(INT8_MIN))      y_c = 32'(INT8_MIN);
    else if (r_c > 34'(INT8_MAX)) y_c = 32'(INT8_MAX);
    else                          y_c = 32'(r_c);
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;

endmodule

// File: rtl/kws_mac_bank_cfu.sv
// KWS custom function unit: accumulator bank, offset SIMD int8 MAC and
// multi-cycle requantize behind the CPU cmd/rsp handshake.
module kws_mac_bank_cfu
  import kws_cfu_pkg::*;
#(
  parameter int unsigned NUM_ACC  = 4,
  parameter int unsigned LANES    = 4,
  parameter int unsigned OFFSET_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int unsigned SEL_W = $clog2(NUM_ACC);

  state_e                      state_q;
  logic [31:0]                 acc_q [NUM_ACC];
  logic signed [OFFSET_W-1:0]  offset_q;
  logic                        rsp_valid_q;
  logic [31:0]                 rsp_data_q;

  fid_t                        fid;
  op_e                         op;
  logic [SEL_W-1:0]            sel;
  logic                        clr;
  logic                        accept_c;
  logic                        rq_valid;
  logic [31:0]                 rq_y;
  logic signed [OFFSET_W:0]    lane_a;
  logic signed [7:0]           lane_b;
  logic signed [OFFSET_W+8:0]  lane_p;
  logic [31:0]                 mac_sum, mac_new;
  logic                        unused_bits;

  assign fid         = fid_t'(cmd_payload_function_id);
  assign op          = op_e'(fid.funct3);
  assign sel         = fid.funct7[SEL_W-1:0];
  assign clr         = fid.funct7[6];
  assign cmd_ready   = (state_q == IDLE);
  assign accept_c    = cmd_valid && cmd_ready;
  assign unused_bits = ^{cmd_payload_inputs_1[15:5], fid.funct7[5:SEL_W]};

  // Per-lane (a + offset) * b, widened to 32 bits before summing.
  always_comb begin
    mac_sum = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_p  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a  = (OFFSET_W+1)'($signed(cmd_payload_inputs_0[8*i +: 8]))
              + (OFFSET_W+1)'(offset_q);
      lane_b  = $signed(cmd_payload_inputs_1[8*i +: 8]);
      lane_p  = lane_a * lane_b;
      mac_sum = mac_sum + 32'(lane_p);
    end
    mac_new = acc_q[sel] + mac_sum;
  end

  kws_requant_unit u_requant (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept_c && (op == REQUANT)),
    .x_i       (acc_q[sel]),
    .m_i       (cmd_payload_inputs_0),
    .shift_i   (cmd_payload_inputs_1[4:0]),
    .out_off_i (cmd_payload_inputs_1[31:16]),
    .valid_o   (rq_valid),
    .y_o       (rq_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      offset_q    <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          case (op)
            SET_OFFSET: begin
              offset_q   <= cmd_payload_inputs_0[OFFSET_W-1:0];
              rsp_data_q <= 32'($signed(cmd_payload_inputs_0[OFFSET_W-1:0]));
            end
            MAC: begin
              acc_q[sel] <= mac_new;
              rsp_data_q <= mac_new;
            end
            READ_ACC: begin
              rsp_data_q <= acc_q[sel];
              if (clr) acc_q[sel] <= '0;
            end
            SET_ACC: begin
              acc_q[sel] <= cmd_payload_inputs_0;
              rsp_data_q <= cmd_payload_inputs_0;
            end
            REQUANT: begin
              state_q     <= RQ_MUL;
              rsp_valid_q <= 1'b0;
            end
            default: rsp_data_q <= '0;
          endcase
        end
        RQ_MUL: state_q <= RQ_RND;
        RQ_RND: if (rq_valid) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= rq_y;
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid               = rsp_valid_q;
  assign rsp_payload_outputs_0   = rsp_data_q;
  assign rsp_payload_response_ok = 1'b1;

endmodule

// File: tb/tb_kws_mac_bank_cfu.sv
// Directed bench for kws_mac_bank_cfu with an arithmetic reference model.
module tb_kws_mac_bank_cfu;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_f7;
  logic [2:0]  cmd_f3;
  logic [31:0] in0, in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic [31:0] rsp_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] acc_m [4];
  int          off_m;
  logic [31:0] exp_data;
  bit          exp_pending;

  always #5 clk = ~clk;

  kws_mac_bank_cfu dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id ({cmd_f7, cmd_f3}),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_ok),
    .rsp_payload_outputs_0   (rsp_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Round to nearest, ties away from zero, of the Q31 product and the shift.
  function automatic logic [31:0] requant_model(input logic [31:0] x, input logic [31:0] m,
                                                input int s, input int oo);
    longint p, h, q, r, rem, y;
    if (x == 32'h8000_0000 && m == 32'h8000_0000) h = 64'sd2147483647;
    else begin
      p = longint'($signed(x)) * longint'($signed(m));
      h = (p + (p >= 0 ? 64'sd1073741824 : -64'sd1073741823)) / 64'sd2147483648;
    end
    q   = 64'sd1 << s;
    r   = h / q;
    rem = h - r * q;
    if (2 * (rem < 0 ? -rem : rem) >= q) r = r + (h < 0 ? -1 : 1);
    y = r + oo;
    if (y < -128) y = -128;
    if (y > 127)  y = 127;
    return 32'(y);
  endfunction

  function automatic logic [31:0] model_op(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
    int          sel = int'(f7[1:0]);
    int          sum = 0;
    logic [31:0] r;
    case (f3)
      3'd0: begin off_m = int'($signed(a[8:0])); return 32'(off_m); end
      3'd1: begin
        for (int i = 0; i < 4; i++)
          sum += (int'($signed(a[8*i +: 8])) + off_m) * int'($signed(b[8*i +: 8]));
        acc_m[sel] = acc_m[sel] + 32'(sum);
        return acc_m[sel];
      end
      3'd2: begin r = acc_m[sel]; if (f7[6]) acc_m[sel] = '0; return r; end
      3'd3: begin acc_m[sel] = a; return a; end
      3'd4: return requant_model(acc_m[sel], a, int'(b[4:0]), int'($signed(b[31:16])));
      default: return '0;
    endcase
  endfunction

  // Every cycle a response is visible it must be expected and match the model.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      chk("rsp_expected", 32'(exp_pending), 32'd1);
      chk("rsp_data", rsp_out, exp_data);
      chk("rsp_ok", 32'(rsp_ok), 32'd1);
    end
  end

  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input bit has_lit, input logic [31:0] lit,
                        input int hold, input bit pulse);
    int          n;
    logic [31:0] got;
    exp_data    = model_op(f7, f3, a, b);
    exp_pending = 1'b1;
    cmd_f7 = f7; cmd_f3 = f3; in0 = a; in1 = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (rsp_valid) break;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    got = rsp_out;
    if (has_lit) chk("literal", got, lit);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (pulse && i == 1) begin
        cmd_f7 = 7'h03; cmd_f3 = 3'd3; in0 = 32'h1234_5678; cmd_valid = 1'b1;
      end else cmd_valid = 1'b0;
      @(negedge clk);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_stable", rsp_out, got);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    exp_pending = 1'b0;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_f7 = '0; cmd_f3 = '0; in0 = '0; in1 = '0;
    rsp_ready = 1'b0; exp_pending = 1'b0; exp_data = '0; off_m = 0;
    for (int i = 0; i < 4; i++) acc_m[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_out", rsp_out, 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    run_op(7'h00, 3'd0, 32'd128, 32'd0, 1, 1'b1, 32'd128, 0, 1'b0);
    run_op(7'h00, 3'd1, 32'h0102_0304, 32'h0101_0101, 1, 1'b1, 32'd522, 0, 1'b0);
    run_op(7'h00, 3'd1, 32'h0102_0304, 32'h0101_0101, 1, 1'b1, 32'd1044, 0, 1'b0);
    run_op(7'h00, 3'd1, 32'h80FF_7F00, 32'h7F80_FF05, 1, 1'b0, 32'd0, 0, 1'b0);

    run_op(7'h02, 3'd3, 32'hDEAD_BEEF, 32'd0, 1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    run_op(7'h42, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    run_op(7'h02, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd2, 32'd0, 32'd0, 1, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h01, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);
    run_op(7'h03, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);

    run_op(7'h01, 3'd3, 32'd1000, 32'd0, 1, 1'b1, 32'd1000, 0, 1'b0);
    run_op(7'h01, 3'd4, 32'h4000_0000, {16'hFFFD, 16'd2}, 3, 1'b1, 32'd122, 0, 1'b0);
    run_op(7'h01, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd1000, 0, 1'b0);

    run_op(7'h00, 3'd3, 32'hFFFF_FFFA, 32'd0, 1, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd4, 32'h7FFF_FFFF, 32'd2, 3, 1'b1, 32'hFFFF_FFFE, 0, 1'b0);
    run_op(7'h00, 3'd3, 32'h8000_0000, 32'd0, 1, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd4, 32'h8000_0000, 32'd0, 3, 1'b1, 32'd127, 0, 1'b0);
    run_op(7'h00, 3'd3, -32'sd100000, 32'd0, 1, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd4, 32'h4000_0000, 32'd0, 3, 1'b1, 32'hFFFF_FF80, 0, 1'b0);
    run_op(7'h00, 3'd3, 32'd1_234_567, 32'd0, 1, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd4, 32'h5555_5555, {16'd5, 16'd13}, 3, 1'b0, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd5, 32'hFFFF_FFFF, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);

    run_op(7'h01, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd1000, 5, 1'b1);
    run_op(7'h03, 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);

    // Reset lands while the requantize is in its rounding stage.
    exp_pending = 1'b0;
    cmd_f7 = 7'h01; cmd_f3 = 3'd4; in0 = 32'h4000_0000; in1 = 32'd2; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    off_m = 0;
    for (int i = 0; i < 4; i++) acc_m[i] = '0;
    @(negedge clk);
    chk("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      run_op(7'(i), 3'd2, 32'd0, 32'd0, 1, 1'b1, 32'd0, 0, 1'b0);
    run_op(7'h00, 3'd1, 32'h0101_0101, 32'h0101_0101, 1, 1'b1, 32'd4, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
